// File: rtl/hazard_unit_if.sv
// hazard_unit_if: hazard-control bundle between the RV32I pipeline and the
// hazard unit. The pipeline side (master) supplies decode/execute/memory
// status; the hazard unit side (slave) returns the stage-register controls,
// status flags and the optional performance counters.
interface hazard_unit_if;
  // decode stage operands
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  // execute stage destination / writeback / branch resolution
  logic [4:0]  ex_rd;
  logic        ex_regwen;
  logic [1:0]  ex_wbsel;
  logic        ex_br_taken;
  // data memory handshake
  logic        mem_req;
  logic        mem_ready;
  // stage register controls
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_hold;
  logic        idex_flush;
  logic        exmem_hold;
  // status
  logic        mem_err;
  logic        busy;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_regwen, ex_wbsel, ex_br_taken,
    output mem_req, mem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush, exmem_hold,
    input  mem_err, busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_regwen, ex_wbsel, ex_br_taken,
    input  mem_req, mem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush, exmem_hold,
    output mem_err, busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: stall / hold / flush sequencing for the RV32I stage registers
// (PC, IF/ID, ID/EX, EX/MEM).
//
// Conditions, highest priority first:
//   mem_wait    : freeze PC, IF/ID, ID/EX and EX/MEM while data memory stalls
//   ex_br_taken : flush IF/ID and ID/EX, then keep flushing IF/ID for
//                 BR_PENALTY-1 further cycles (REDIRECT state)
//   load_use    : hold PC and IF/ID, inject a bubble into ID/EX
//
// A memory wait arriving during REDIRECT parks the redirect count and the
// FSM resumes REDIRECT once the access completes. The cycle in which the
// memory access completes is evaluated as the resumed state, so a branch
// (or the remaining redirect work) is processed in that same cycle.
//
// All control outputs are combinational and forced low while rst is high so
// that reset takes effect without waiting for an edge.
//
// Optional feature macro: HAZARD_PERF_EN
//   defined   : stall_cnt / flush_cnt are live 32-bit wrapping counters
//   undefined : both read as constant 0, no counter flops
module hazard_unit #(
  parameter int unsigned BR_PENALTY  = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [1:0]  LOAD_WBSEL  = 2'b01
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hz
);

  // wait counter is at least 8 bits and wide enough to reach MEM_TIMEOUT
  localparam int unsigned TO_BITS = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned WCNT_W  = (TO_BITS > 8) ? TO_BITS : 8;

  // cycles of extra IF/ID flushing after the branch cycle itself
  localparam logic [2:0] RCNT_INIT = 3'(BR_PENALTY - 1);
  localparam bit         USE_REDIR = (BR_PENALTY > 1);
  localparam bit         USE_TO    = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          rcnt_q, rcnt_d;
  logic                ret_redir_q, ret_redir_d;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                err_q;

  logic mem_wait;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic eff_redir;
  logic to_hit;

  logic pc_stall_c;
  logic ifid_stall_c;
  logic ifid_flush_c;
  logic idex_hold_c;
  logic idex_flush_c;
  logic exmem_hold_c;

  // saturating increment for the consecutive-wait counter
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign mem_wait = hz.mem_req & ~hz.mem_ready;

  assign rs1_hit  = hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd);
  assign rs2_hit  = hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd);
  assign load_use = hz.ex_regwen & (hz.ex_wbsel == LOAD_WBSEL) &
                    (hz.ex_rd != 5'd0) & (rs1_hit | rs2_hit);

  // REDIRECT work is pending either in REDIRECT itself or parked in MEM_WAIT
  assign eff_redir = (state_q == REDIRECT) |
                     ((state_q == MEM_WAIT) & ret_redir_q);

  assign to_hit = USE_TO && (wcnt_q == WCNT_W'(MEM_TIMEOUT));

  // next-state and stage-control decode, highest priority condition wins
  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    ret_redir_d  = ret_redir_q;
    pc_stall_c   = 1'b0;
    ifid_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    idex_hold_c  = 1'b0;
    idex_flush_c = 1'b0;
    exmem_hold_c = 1'b0;

    if (mem_wait) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      idex_hold_c  = 1'b1;
      exmem_hold_c = 1'b1;
      state_d      = MEM_WAIT;
      // remember where to resume only on entry; rcnt stays parked
      if (state_q != MEM_WAIT) begin
        ret_redir_d = (state_q == REDIRECT);
      end
    end else if (eff_redir) begin
      ifid_flush_c = 1'b1;
      if (rcnt_q <= 3'd1) begin
        state_d     = RUN;
        rcnt_d      = 3'd0;
        ret_redir_d = 1'b0;
      end else begin
        state_d = REDIRECT;
        rcnt_d  = rcnt_q - 3'd1;
      end
    end else begin
      state_d     = RUN;
      ret_redir_d = 1'b0;
      if (hz.ex_br_taken) begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        if (USE_REDIR) begin
          state_d = REDIRECT;
          rcnt_d  = RCNT_INIT;
        end
      end else if (load_use) begin
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        idex_flush_c = 1'b1;
      end
    end
  end

  // FSM, redirect counter and return-state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      rcnt_q      <= 3'd0;
      ret_redir_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      ret_redir_q <= ret_redir_d;
    end
  end

  // consecutive memory-wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= mem_wait ? sat_inc(wcnt_q) : '0;
      err_q  <= err_q | to_hit;
    end
  end

  assign hz.pc_stall   = pc_stall_c   & ~rst;
  assign hz.ifid_stall = ifid_stall_c & ~rst;
  assign hz.ifid_flush = ifid_flush_c & ~rst;
  assign hz.idex_hold  = idex_hold_c  & ~rst;
  assign hz.idex_flush = idex_flush_c & ~rst;
  assign hz.exmem_hold = exmem_hold_c & ~rst;
  assign hz.mem_err    = (err_q | to_hit) & ~rst;
  assign hz.busy       = (state_q != RUN) & ~rst;

`ifdef HAZARD_PERF_EN
  logic        br_accept;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // a branch is accepted only when it actually drives the flush pair
  assign br_accept = hz.ex_br_taken & ~mem_wait & ~eff_redir;

  // stall-cycle and accepted-redirect event counters, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, pc_stall_c};
      flush_cnt_q <= flush_cnt_q + {31'd0, br_accept};
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit. Two instances share one
// stimulus stream: dut_a (BR_PENALTY=3, MEM_TIMEOUT=3) and dut_b
// (BR_PENALTY=4, MEM_TIMEOUT=255). Expected output vectors are pushed when a
// cycle's stimulus is driven and popped/compared on the following negedge.
// Output vector bit order: {pc_stall, ifid_stall, ifid_flush, idex_hold,
// idex_flush, exmem_hold, mem_err, busy}.
module tb_hazard_unit;

  logic clk;
  logic rst;

  hazard_unit_if bus ();
  hazard_unit_if busb ();

  assign busb.id_rs1      = bus.id_rs1;
  assign busb.id_rs2      = bus.id_rs2;
  assign busb.id_use_rs1  = bus.id_use_rs1;
  assign busb.id_use_rs2  = bus.id_use_rs2;
  assign busb.ex_rd       = bus.ex_rd;
  assign busb.ex_regwen   = bus.ex_regwen;
  assign busb.ex_wbsel    = bus.ex_wbsel;
  assign busb.ex_br_taken = bus.ex_br_taken;
  assign busb.mem_req     = bus.mem_req;
  assign busb.mem_ready   = bus.mem_ready;

  hazard_unit #(.BR_PENALTY(3), .MEM_TIMEOUT(3), .LOAD_WBSEL(2'b01)) dut_a (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  hazard_unit #(.BR_PENALTY(4), .MEM_TIMEOUT(255), .LOAD_WBSEL(2'b01)) dut_b (
    .clk (clk),
    .rst (rst),
    .hz  (busb)
  );

`ifdef HAZARD_PERF_EN
  localparam logic [31:0] PERF_ON = 32'd1;
`else
  localparam logic [31:0] PERF_ON = 32'd0;
`endif

  localparam logic [7:0] E_NONE = 8'b0000_0000;
  localparam logic [7:0] E_LU   = 8'b1100_1000;
  localparam logic [7:0] E_BR   = 8'b0010_1000;
  localparam logic [7:0] E_RD   = 8'b0010_0001;
  localparam logic [7:0] E_FRZ0 = 8'b1101_0100;
  localparam logic [7:0] E_FRZ  = 8'b1101_0101;
  localparam logic [7:0] E_FERR = 8'b1101_0111;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  tests = 0;
  int  fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // {rs1, rs2, use1, use2, rd, regwen, wbsel, br, req, rdy}
  function automatic logic [22:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic u1, input logic u2,
                                     input logic [4:0] rd, input logic wen,
                                     input logic [1:0] wbsel, input logic br,
                                     input logic req, input logic rdy);
    return {rs1, rs2, u1, u2, rd, wen, wbsel, br, req, rdy};
  endfunction

  task automatic apply(input logic [22:0] s);
    bus.id_rs1      = s[22:18];
    bus.id_rs2      = s[17:13];
    bus.id_use_rs1  = s[12];
    bus.id_use_rs2  = s[11];
    bus.ex_rd       = s[10:6];
    bus.ex_regwen   = s[5];
    bus.ex_wbsel    = s[4:3];
    bus.ex_br_taken = s[2];
    bus.mem_req     = s[1];
    bus.mem_ready   = s[0];
  endtask

  function automatic logic [7:0] obs_a();
    return {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_hold,
            bus.idex_flush, bus.exmem_hold, bus.mem_err, bus.busy};
  endfunction

  function automatic logic [7:0] obs_b();
    return {busb.pc_stall, busb.ifid_stall, busb.ifid_flush, busb.idex_hold,
            busb.idex_flush, busb.exmem_hold, busb.mem_err, busb.busy};
  endfunction

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    apply(23'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sb_t e;
    logic [7:0] o;
    // reset held with every hazard source active: outputs must stay low
    rst = 1'b1;
    apply(mk(5, 0, 1, 0, 5, 1, 2'b01, 1, 1, 0));
    sbq.push_back('{name: "reset_a", exp: E_NONE});
    sbq.push_back('{name: "reset_b", exp: E_NONE});
    @(negedge clk);
    e = sbq.pop_front(); o = obs_a(); tests++;
    if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    e = sbq.pop_front(); o = obs_b(); tests++;
    if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    tests++;
    if (busb.stall_cnt !== 32'd0 || busb.flush_cnt !== 32'd0) begin
      fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", busb.stall_cnt, busb.flush_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    apply(23'd0);
    sbq.push_back('{name: "reset_release", exp: E_NONE});
    @(negedge clk);
    e = sbq.pop_front(); o = obs_a(); tests++;
    if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
  endtask

  task automatic test_load_use();
    logic [22:0] st[7];
    logic [7:0]  ex[7];
    sb_t e;
    logic [7:0] o;
    reset_dut();
    st = '{mk(5, 0, 1, 0, 5, 1, 2'b01, 0, 0, 0),   // rs1 load-use
           mk(5, 0, 1, 0, 9, 1, 2'b01, 0, 0, 0),   // bubble now in EX
           mk(0, 0, 1, 0, 0, 1, 2'b01, 0, 0, 0),   // ex_rd = x0
           mk(3, 7, 0, 1, 7, 1, 2'b01, 0, 0, 0),   // rs2 load-use
           mk(7, 0, 1, 0, 7, 1, 2'b00, 0, 0, 0),   // not a load
           mk(7, 0, 0, 0, 7, 1, 2'b01, 0, 0, 0),   // operand unused
           mk(7, 0, 1, 0, 7, 0, 2'b01, 0, 0, 0)};  // no writeback
    ex = '{E_LU, E_NONE, E_NONE, E_LU, E_NONE, E_NONE, E_NONE};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      sbq.push_back('{name: $sformatf("load_use[%0d]", i), exp: ex[i]});
      @(negedge clk);
      e = sbq.pop_front(); o = obs_a(); tests++;
      if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    end
    tests++;
    if (bus.stall_cnt !== PERF_ON * 32'd2) begin
      fails++; $display("FAIL load_use_stall_cnt: got %0d expected %0d", bus.stall_cnt, PERF_ON * 32'd2);
    end
  endtask

  task automatic test_branch();
    logic [22:0] st[5];
    logic [7:0]  ex[5];
    sb_t e;
    logic [7:0] o;
    reset_dut();
    st = '{mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0),   // branch taken
           mk(5, 0, 1, 0, 5, 1, 2'b01, 1, 0, 0),   // masked branch + load-use
           23'd0,
           23'd0,
           mk(5, 0, 1, 0, 5, 1, 2'b01, 0, 0, 0)};  // load-use back in RUN
    ex = '{E_BR, E_RD, E_RD, E_NONE, E_LU};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      sbq.push_back('{name: $sformatf("branch[%0d]", i), exp: ex[i]});
      @(negedge clk);
      e = sbq.pop_front(); o = obs_a(); tests++;
      if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    end
    tests++;
    if (bus.flush_cnt !== PERF_ON) begin
      fails++; $display("FAIL branch_flush_cnt: got %0d expected %0d", bus.flush_cnt, PERF_ON);
    end
    tests++;
    if (bus.stall_cnt !== 32'd0) begin
      fails++; $display("FAIL branch_stall_cnt: got %0d expected 0", bus.stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    logic [22:0] st[6];
    logic [7:0]  ex[6];
    sb_t e;
    logic [7:0] o;
    reset_dut();
    st = '{mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0),
           mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0),
           mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0),
           mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0),
           mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1),   // ready cycle
           23'd0};
    ex = '{E_FRZ0, E_FRZ, E_FRZ, E_FRZ, 8'b0000_0001, E_NONE};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      sbq.push_back('{name: $sformatf("mem_wait[%0d]", i), exp: ex[i]});
      @(negedge clk);
      e = sbq.pop_front(); o = obs_b(); tests++;
      if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    end
    tests++;
    if (busb.stall_cnt !== PERF_ON * 32'd4) begin
      fails++; $display("FAIL mem_wait_stall_cnt: got %0d expected %0d", busb.stall_cnt, PERF_ON * 32'd4);
    end
  endtask

  task automatic test_simultaneous();
    logic [22:0] st[6];
    logic [7:0]  ex[6];
    sb_t e;
    logic [7:0] o;
    reset_dut();
    st = '{mk(5, 0, 1, 0, 5, 1, 2'b01, 1, 1, 0),
           mk(5, 0, 1, 0, 5, 1, 2'b01, 1, 1, 0),
           mk(5, 0, 1, 0, 5, 1, 2'b01, 1, 1, 1),   // ready: branch accepted
           23'd0,
           23'd0,
           23'd0};
    ex = '{E_FRZ0, E_FRZ, 8'b0010_1001, E_RD, E_RD, E_NONE};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      sbq.push_back('{name: $sformatf("simult[%0d]", i), exp: ex[i]});
      @(negedge clk);
      e = sbq.pop_front(); o = obs_a(); tests++;
      if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    end
    tests++;
    if (bus.flush_cnt !== PERF_ON || bus.stall_cnt !== PERF_ON * 32'd2) begin
      fails++; $display("FAIL simult_cnt: got %0d/%0d expected %0d/%0d",
                        bus.flush_cnt, bus.stall_cnt, PERF_ON, PERF_ON * 32'd2);
    end
  endtask

  task automatic test_redirect_wait();
    logic [22:0] st[6];
    logic [7:0]  ex[6];
    sb_t e;
    logic [7:0] o;
    reset_dut();
    st = '{mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0),   // branch
           mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0),   // wait during REDIRECT
           mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0),
           mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 1),   // ready: redirect resumes
           23'd0,
           23'd0};
    ex = '{E_BR, E_FRZ, E_FRZ, E_RD, E_RD, E_NONE};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      sbq.push_back('{name: $sformatf("redir_wait[%0d]", i), exp: ex[i]});
      @(negedge clk);
      e = sbq.pop_front(); o = obs_a(); tests++;
      if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    end
    tests++;
    if (bus.flush_cnt !== PERF_ON) begin
      fails++; $display("FAIL redir_wait_flush_cnt: got %0d expected %0d", bus.flush_cnt, PERF_ON);
    end
  endtask

  task automatic test_timeout();
    logic [22:0] st[8];
    logic [7:0]  ex[8];
    sb_t e;
    logic [7:0] o;
    reset_dut();
    st = '{mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0),
           mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0),
           mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0),
           mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0),   // wcnt reaches 3
           mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0),
           mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1),
           23'd0,
           23'd0};
    ex = '{E_FRZ0, E_FRZ, E_FRZ, E_FERR, E_FERR, 8'b0000_0011, 8'b0000_0010, 8'b0000_0010};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      sbq.push_back('{name: $sformatf("timeout[%0d]", i), exp: ex[i]});
      @(negedge clk);
      e = sbq.pop_front(); o = obs_a(); tests++;
      if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    end
    tests++;
    if (busb.mem_err !== 1'b0) begin
      fails++; $display("FAIL timeout_b_no_err: got %b expected 0", busb.mem_err);
    end
    reset_dut();
    sbq.push_back('{name: "timeout_cleared", exp: E_NONE});
    @(negedge clk);
    e = sbq.pop_front(); o = obs_a(); tests++;
    if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
  endtask

  task automatic test_reset_mid_redirect();
    sb_t e;
    logic [7:0] o;
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      apply((i == 0) ? mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0) : 23'd0);
      sbq.push_back('{name: $sformatf("rst_redir[%0d]", i), exp: (i == 0) ? E_BR : E_RD});
      @(negedge clk);
      e = sbq.pop_front(); o = obs_b(); tests++;
      if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    end
    tests++;
    if (busb.flush_cnt !== PERF_ON) begin
      fails++; $display("FAIL rst_redir_flush_cnt: got %0d expected %0d", busb.flush_cnt, PERF_ON);
    end
    // cycle 2 of the redirect: reset with a branch still presented
    @(posedge clk); #1;
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    sbq.push_back('{name: "rst_redir_in_reset", exp: E_NONE});
    @(negedge clk);
    e = sbq.pop_front(); o = obs_b(); tests++;
    if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    tests++;
    if (busb.flush_cnt !== 32'd0 || busb.stall_cnt !== 32'd0) begin
      fails++; $display("FAIL rst_redir_cnt: got %0d/%0d expected 0/0", busb.flush_cnt, busb.stall_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    apply(23'd0);
    sbq.push_back('{name: "rst_redir_run", exp: E_NONE});
    @(negedge clk);
    e = sbq.pop_front(); o = obs_b(); tests++;
    if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    sbq.push_back('{name: "rst_redir_new_branch", exp: E_BR});
    @(negedge clk);
    e = sbq.pop_front(); o = obs_b(); tests++;
    if (o !== e.exp) begin fails++; $display("FAIL %s: got %b expected %b", e.name, o, e.exp); end
  endtask

  initial begin
    rst = 1'b1;
    apply(23'd0);
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_simultaneous();
    test_redirect_wait();
    test_timeout();
    test_reset_mid_redirect();
    @(posedge clk); #1;
    apply(23'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
